uart_rx_core: RTL
=================

# uart_rx_core

UART receive engine for the SimpleRISC SoC peripheral bus. It consumes the conditioned serial line from the pull-up stage and samples it at bit centres. It deframes 8-N-1 characters (8-E-1 when parity is compiled in) and holds one received byte for the CPU-side register block, with framing, parity and overrun status.

## Interface
- `CLKS_PER_BIT`, default 868 (100 MHz / 115200), clocks per bit period; legal range 4..65535.
- `clk` input 1: system clock, all logic on rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `RX_serial_in` input 1: serial line from the pull-up stage; idle high, asynchronous to `clk`.
- `rx_data` output 8: last accepted byte, LSB = first data bit on the wire.
- `rx_valid` output 1: level; `rx_data` holds an unread byte.
- `rx_ack` input 1: one-cycle consume strobe; ignored while `rx_valid`=0.
- `frame_err` output 1: one-cycle pulse, stop bit sampled 0.
- `parity_err` output 1: one-cycle pulse, parity mismatch; constant 0 without the parity macro.
- `overrun` output 1: sticky; a good byte arrived while `rx_valid`=1.
- `busy` output 1: FSM not in IDLE.

## Operation
- Input passes a 2-flop synchronizer. A falling edge is detected against a third history flop.
- FSM states: IDLE, START, DATA, PARITY (macro only), STOP, BRK_WAIT.
- IDLE: a synced falling edge moves the FSM to START and clears the bit counter `cnt`.
- START: sample at `cnt` = `CLKS_PER_BIT/2`-1 (integer division).
  - Sample 0: go to DATA, `cnt`=0.
  - Sample 1: glitch; return to IDLE with no outputs touched.
- DATA: sample at `cnt` = `CLKS_PER_BIT`-1, then restart `cnt`. The sampled bit shifts into bit 7 of the shift register (right shift). After the 8th sample, go to STOP, or to PARITY when parity is compiled in.
- PARITY: one sample; even parity over 8 data bits plus the parity bit must be 0. Then go to STOP.
- STOP: one sample.
  - Sample 1 with no parity error: byte is good; go to IDLE.
  - Sample 1 with a parity error: pulse `parity_err`, drop the byte, go to IDLE.
  - Sample 0: pulse `frame_err`, drop the byte, go to BRK_WAIT.
- BRK_WAIT: stay until the synced line is 1, then go to IDLE. A held-low line therefore never starts a new frame.
- Good byte while `rx_valid`=0: load `rx_data`, set `rx_valid`.
- Good byte while `rx_valid`=1 with no `rx_ack` in the same cycle: keep the old byte, discard the new one, set `overrun`.
- Good byte in the same cycle as `rx_ack`: load the new byte, `rx_valid` stays 1, no overrun.
- `rx_ack` with `rx_valid`=1 and no new byte: clear `rx_valid` and `overrun` on the next edge.
- The FSM returns to IDLE at the stop-bit centre, so back-to-back frames with a single stop bit are received without loss.

## Timing
- Reset values: FSM=IDLE, `cnt`=0, synchronizer and history flops=1, `rx_data`=0x00, `rx_valid`=0, `frame_err`=0, `parity_err`=0, `overrun`=0, `busy`=0.
- Reset asserted mid-frame aborts immediately; no partial byte or status pulse is produced.
- Edge-to-START: the synced low appears 2 edges after the pin falls; IDLE→START occurs on the 3rd edge.
- `rx_valid` rises exactly 3 + `CLKS_PER_BIT/2` + 9·`CLKS_PER_BIT` edges after the first edge that samples the pin low. Use 10·`CLKS_PER_BIT` in place of 9·`CLKS_PER_BIT` when parity is compiled in.
- `frame_err` and `parity_err` assert on the same edge that `rx_valid` would have risen and last exactly one cycle.
- `busy` is high from the START entry edge through the edge that returns the FSM to IDLE.
- Sample-point tolerance: at most ±1 clk relative to the ideal centre, so the design tolerates up to ±4 % baud mismatch at `CLKS_PER_BIT` ≥ 16.

## Configuration
- `UART_RX_PARITY_EN` defined: the PARITY state is compiled in; frames are 8-E-1 and `parity_err` is live.
- `UART_RX_PARITY_EN` undefined: the PARITY state and parity logic are absent; frames are 8-N-1 and `parity_err` is tied to 0.

## Test plan
All scenarios use `CLKS_PER_BIT`=16.
- Single frame: send 0xA5 8-N-1 → `rx_valid` rises 3+8+144=155 edges after the pin falls, `rx_data`=0xA5, no error pulses.
- Glitch: drive the line low for 5 clks, then high → `busy` pulses, then returns to IDLE; `rx_valid`, `frame_err` and `overrun` stay 0.
- Framing/break: send 0x3C with stop=0 and hold the line low for 40 bit times → one `frame_err` pulse, `rx_valid`=0, no new frame until the line returns high. Then send 0x11 → `rx_data`=0x11.
- Overrun and same-cycle acknowledge:
  - Send 0x01 then 0x02 back-to-back without `rx_ack` → `rx_data`=0x01, `overrun`=1; `rx_ack` then clears both.
  - Repeat with `rx_ack` on the valid edge of 0x02 → `rx_data`=0x02, `overrun`=0.
- Reset mid-frame: assert `rst` during data bit 4 of 0xFF → all outputs at reset values. A following 0x5A frame is received correctly.
- Parity (with `UART_RX_PARITY_EN`):
  - 0x07 with parity bit 1 → `rx_data`=0x07.
  - 0x07 with parity bit 0 → one `parity_err` pulse, `rx_valid`=0.

Source files
------------

// File: rtl/uart_rx_core.sv
// uart_rx_core: UART receive engine, 8-N-1 (8-E-1 with UART_RX_PARITY_EN) sampled at bit centres.
// Ports: clk, rst (async, active-high), RX_serial_in (idle-high line), rx_ack (consume strobe),
//        rx_data/rx_valid (held byte), frame_err/parity_err (one-cycle pulses), overrun (sticky), busy.
// Optional macro UART_RX_PARITY_EN compiles in the PARITY state and live parity_err.
module uart_rx_core #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RX_serial_in,
  input  logic       rx_ack,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       overrun,
  output logic       busy
);
`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK_WAIT, PARITY} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK_WAIT} state_t;
`endif
  localparam logic [15:0] HALF_M1 = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] FULL_M1 = 16'(CLKS_PER_BIT - 1);
  state_t state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d, rx_data_q, rx_data_d;
  logic sync1_q, sync2_q, hist_q;
  logic rx_valid_q, rx_valid_d, frame_err_q, frame_err_d, overrun_q, overrun_d;
  logic good, ack, par_bad;
`ifdef UART_RX_PARITY_EN
  logic par_bad_q, par_bad_d, parity_err_q, parity_err_d;
  assign par_bad = par_bad_q;
  assign parity_err = parity_err_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      par_bad_q <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      par_bad_q <= par_bad_d;
      parity_err_q <= parity_err_d;
    end
`else
  assign par_bad = 1'b0;
  assign parity_err = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      shift_q <= '0;
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      hist_q <= 1'b1;
      rx_data_q <= '0;
      rx_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      shift_q <= shift_d;
      sync1_q <= RX_serial_in;
      sync2_q <= sync1_q;
      hist_q <= sync2_q;
      rx_data_q <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q <= overrun_d;
    end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q + 16'd1;
    bit_d = bit_q;
    shift_d = shift_q;
    frame_err_d = 1'b0;
    good = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
    parity_err_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (hist_q && !sync2_q) state_d = START;
      end
      START:
        if (cnt_q == HALF_M1) begin
          cnt_d = '0;
          bit_d = '0;
          state_d = sync2_q ? IDLE : DATA;
        end
      DATA:
        if (cnt_q == FULL_M1) begin
          cnt_d = '0;
          shift_d = {sync2_q, shift_q[7:1]};
          bit_d = bit_q + 3'd1;
`ifdef UART_RX_PARITY_EN
          if (bit_q == 3'd7) state_d = PARITY;
`else
          if (bit_q == 3'd7) state_d = STOP;
`endif
        end
`ifdef UART_RX_PARITY_EN
      PARITY:
        if (cnt_q == FULL_M1) begin
          cnt_d = '0;
          par_bad_d = ^{shift_q, sync2_q};
          state_d = STOP;
        end
`endif
      STOP:
        if (cnt_q == FULL_M1) begin
          cnt_d = '0;
          state_d = sync2_q ? IDLE : BRK_WAIT;
          frame_err_d = !sync2_q;
          good = sync2_q && !par_bad;
`ifdef UART_RX_PARITY_EN
          parity_err_d = sync2_q && par_bad;
`endif
        end
      BRK_WAIT: begin
        cnt_d = '0;
        if (sync2_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    ack = rx_ack && rx_valid_q;
    rx_valid_d = good || (rx_valid_q && !ack);
    rx_data_d = (good && (!rx_valid_q || ack)) ? shift_q : rx_data_q;
    overrun_d = (good && rx_valid_q && !ack) ? 1'b1 : (ack ? 1'b0 : overrun_q);
  end
  assign rx_data = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun = overrun_q;
  assign busy = state_q != IDLE;
endmodule
